// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional bus lock is enabled by defining MEM_ARB_LOCK_EN.
package mem_arb_pkg;

    localparam int ARB_AW = 16;
    localparam int ARB_DW = 8;

    localparam logic ARB_PORT_CPU = 1'b0;
    localparam logic ARB_PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } arb_state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// lock0/lock1 exist only when MEM_ARB_LOCK_EN is defined.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);

    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
`ifdef MEM_ARB_LOCK_EN
    logic          lock0;
    logic          lock1;
`endif
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata0, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata0, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker with a lock hold override.
// hold_i is only ever raised when MEM_ARB_LOCK_EN is defined.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] elig_i,
    input  logic       ptr_i,
    input  logic       hold_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    // Hold favours the last grant; otherwise the other port wins ties.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = ptr_i;
        if (hold_i) begin
            gnt_vld_o = elig_i[ptr_i];
            gnt_idx_o = ptr_i;
        end else if (&elig_i) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = ~ptr_i;
        end else if (|elig_i) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = elig_i[1] ? ARB_PORT_LDR : ARB_PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter onto one synchronous-read memory port.
// Define MEM_ARB_LOCK_EN to let a granted port keep the bus via lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          ptr_q;
    logic          port_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          ack0_q;
    logic          ack1_q;
    logic [1:0]    elig;
    logic          gnt_vld;
    logic          gnt_idx;
    logic          hold;
    logic          grant;

    // A port in its ack cycle may still show req; it must not re-win.
    assign elig  = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};
    assign grant = (state_q == IDLE) && gnt_vld;

`ifdef MEM_ARB_LOCK_EN
    logic hold_q;
    logic lock_sel;

    assign lock_sel = ptr_q ? bus.lock1 : bus.lock0;
    assign hold     = lock_sel & (ack0_q | ack1_q | hold_q);

    // Remember a locked ack until the locked port returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else if (state_q == IDLE) begin
            hold_q <= grant ? 1'b0 : hold;
        end
    end
`else
    assign hold = 1'b0;
`endif

    mem_arb_rr u_rr (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .hold_i    (hold),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one access per IDLE -> ISSUE -> CAPTURE round.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_vld) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request and advance the last-grant pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            ptr_q   <= gnt_idx;
            port_q  <= gnt_idx;
            we_q    <= gnt_idx ? bus.we1 : bus.we0;
            addr_q  <= gnt_idx ? bus.addr1 : bus.addr0;
            wdata_q <= gnt_idx ? bus.wdata1 : bus.wdata0;
        end
    end

    // Capture read data and raise the one-cycle ack of the granted port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack0_q <= (state_q == CAPTURE) && (port_q == ARB_PORT_CPU);
            ack1_q <= (state_q == CAPTURE) && (port_q == ARB_PORT_LDR);
            if (state_q == CAPTURE && !we_q) begin
                if (port_q == ARB_PORT_LDR) rdata1_q <= bus.mem_rdata;
                else                        rdata0_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

endmodule
